// File: rtl/food_spawner.sv
// Food placement engine: draws random grid cells, rejects out-of-range or occupied ones,
// and falls back to a row-major scan of the occupancy memory after MAX_TRIES misses.
module food_spawner #(
    parameter int GRID_W    = 32,
    parameter int GRID_H    = 24,
    parameter int X_BITS    = 5,
    parameter int Y_BITS    = 5,
    parameter int MAX_TRIES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       rnd,
    input  logic              spawn_req,
    output logic [X_BITS-1:0] occ_x,
    output logic [Y_BITS-1:0] occ_y,
    input  logic              occ_hit,
    output logic [X_BITS-1:0] food_x,
    output logic [Y_BITS-1:0] food_y,
    output logic              food_valid,
    output logic              busy,
    output logic              done,
    output logic              fail
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_PROBE,
        S_CHECK,
        S_SCAN_INIT,
        S_DONE,
        S_FAIL
    } state_t;

    localparam logic [X_BITS:0]   GRID_W_L = (X_BITS+1)'(GRID_W);
    localparam logic [Y_BITS:0]   GRID_H_L = (Y_BITS+1)'(GRID_H);
    localparam logic [X_BITS-1:0] LAST_X   = X_BITS'(GRID_W - 1);
    localparam logic [Y_BITS-1:0] LAST_Y   = Y_BITS'(GRID_H - 1);
    localparam logic [7:0]        MAX_T    = 8'(MAX_TRIES);

    state_t            state_q, state_d;
    logic [7:0]        tries_q, tries_d;
    logic              scan_q, scan_d;
    logic [X_BITS-1:0] occ_x_q, occ_x_d;
    logic [Y_BITS-1:0] occ_y_q, occ_y_d;
    logic [X_BITS-1:0] food_x_q, food_x_d;
    logic [Y_BITS-1:0] food_y_q, food_y_d;
    logic              food_valid_q, food_valid_d;

    logic [X_BITS-1:0] cand_x;
    logic [Y_BITS-1:0] cand_y;
    logic              cand_ok;
    logic [7:0]        tries_inc;
    logic              unused_rnd;

    assign cand_x     = rnd[X_BITS-1:0];
    assign cand_y     = rnd[8+Y_BITS-1:8];
    assign cand_ok    = ({1'b0, cand_x} < GRID_W_L) && ({1'b0, cand_y} < GRID_H_L);
    assign tries_inc  = tries_q + 8'd1;
    assign unused_rnd = ^rnd;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            tries_q      <= '0;
            scan_q       <= 1'b0;
            occ_x_q      <= '0;
            occ_y_q      <= '0;
            food_x_q     <= '0;
            food_y_q     <= '0;
            food_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tries_q      <= tries_d;
            scan_q       <= scan_d;
            occ_x_q      <= occ_x_d;
            occ_y_q      <= occ_y_d;
            food_x_q     <= food_x_d;
            food_y_q     <= food_y_d;
            food_valid_q <= food_valid_d;
        end
    end

    // In scan mode the probe address doubles as the scan position.
    always_comb begin
        state_d      = state_q;
        tries_d      = tries_q;
        scan_d       = scan_q;
        occ_x_d      = occ_x_q;
        occ_y_d      = occ_y_q;
        food_x_d     = food_x_q;
        food_y_d     = food_y_q;
        food_valid_d = food_valid_q;

        unique case (state_q)
            S_IDLE: begin
                if (spawn_req) begin
                    state_d      = S_SAMPLE;
                    food_valid_d = 1'b0;
                    tries_d      = '0;
                    scan_d       = 1'b0;
                end
            end
            S_SAMPLE: begin
                tries_d = tries_inc;
                if (cand_ok) begin
                    occ_x_d = cand_x;
                    occ_y_d = cand_y;
                    state_d = S_PROBE;
                end else if (tries_inc >= MAX_T) begin
                    state_d = S_SCAN_INIT;
                end
            end
            S_PROBE: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (!occ_hit) begin
                    food_x_d     = occ_x_q;
                    food_y_d     = occ_y_q;
                    food_valid_d = 1'b1;
                    state_d      = S_DONE;
                end else if (scan_q) begin
                    if (occ_x_q == LAST_X && occ_y_q == LAST_Y) begin
                        state_d = S_FAIL;
                    end else if (occ_x_q == LAST_X) begin
                        occ_x_d = '0;
                        occ_y_d = occ_y_q + 1'b1;
                        state_d = S_PROBE;
                    end else begin
                        occ_x_d = occ_x_q + 1'b1;
                        state_d = S_PROBE;
                    end
                end else if (tries_q >= MAX_T) begin
                    state_d = S_SCAN_INIT;
                end else begin
                    state_d = S_SAMPLE;
                end
            end
            S_SCAN_INIT: begin
                occ_x_d = '0;
                occ_y_d = '0;
                scan_d  = 1'b1;
                state_d = S_PROBE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_FAIL: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign occ_x      = occ_x_q;
    assign occ_y      = occ_y_q;
    assign food_x     = food_x_q;
    assign food_y     = food_y_q;
    assign food_valid = food_valid_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign fail       = (state_q == S_FAIL);

endmodule

// File: doc/food_spawner.md
Name: food_spawner

Overview:
- Consumes the free-running 16-bit pseudo-random word and places a new food cell on the snake grid.
- Cells that are outside the grid or occupied by the snake are rejected; the block retries with the next random word.
- After MAX_TRIES failed random attempts, it falls back to a deterministic row-major scan.
- Sits between the random generator, the occupancy memory (synchronous read, 1-cycle latency) and the game controller.

Parameters:
- GRID_W, 32, grid width in cells; valid x = 0..GRID_W-1
- GRID_H, 24, grid height in cells; valid y = 0..GRID_H-1
- X_BITS, 5, width of x coordinate; must satisfy 2^X_BITS >= GRID_W
- Y_BITS, 5, width of y coordinate; must satisfy 2^Y_BITS >= GRID_H
- MAX_TRIES, 64, random attempts before scan fallback (1..255)

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- rnd  in  16  random word; changes every cycle
- spawn_req  in  1  request a new food cell; sampled only in IDLE
- occ_x  out  X_BITS  occupancy memory read address, x
- occ_y  out  Y_BITS  occupancy memory read address, y
- occ_hit  in  1  1 = cell occupied; valid in the cycle after occ_x/occ_y are presented
- food_x  out  X_BITS  placed food x
- food_y  out  Y_BITS  placed food y
- food_valid  out  1  food_x/food_y hold a placed cell
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on successful placement
- fail  out  1  one-cycle pulse when the grid is full

Behaviour:
- Reset: state=IDLE. All outputs 0, including occ_x, occ_y, food_x, food_y. Try counter and scan position are 0. Reset wins over every other event, including mid-search; any search in progress is abandoned and no done/fail pulse is emitted.
- Candidate extraction in SAMPLE: cand_x = rnd[X_BITS-1:0], cand_y = rnd[8+Y_BITS-1:8]. Candidates are never reduced by modulo.
- IDLE:
  - spawn_req=1 → SAMPLE.
  - On acceptance: food_valid←0, try counter←0.
- SAMPLE:
  - Try counter increments on every SAMPLE cycle.
  - cand_x >= GRID_W or cand_y >= GRID_H → stay in SAMPLE (retry with next rnd), unless the counter reaches MAX_TRIES, which → SCAN_INIT.
  - Otherwise occ_x/occ_y ← candidate (registered), → PROBE.
- PROBE: address held stable for one cycle; → CHECK.
- CHECK (occ_hit valid this cycle):
  - occ_hit=0 → food_x/food_y ← occ_x/occ_y, → DONE.
  - occ_hit=1, random mode → SAMPLE, or SCAN_INIT if the try counter has reached MAX_TRIES.
  - occ_hit=1, scan mode → advance the scan position row-major (x+1; at x=GRID_W-1 wrap x to 0 and increment y) and → PROBE with the new address.
  - occ_hit=1 at (GRID_W-1, GRID_H-1) in scan mode → FAIL.
- SCAN_INIT: scan position ← (0,0); occ_x/occ_y ← (0,0); scan mode set; → PROBE.
- DONE: done=1, food_valid←1; → IDLE. food_x/food_y/food_valid then hold until the next accepted spawn_req or reset.
- FAIL: fail=1, food_valid stays 0; → IDLE.
- Best-case latency: spawn_req sampled in cycle N → SAMPLE in N+1 → PROBE in N+2 → CHECK in N+3 → done=1 with valid food in N+4 → IDLE in N+5.
- Each occupied random candidate costs 3 cycles; each out-of-range candidate costs 1 cycle; each scan cell costs 2 cycles.
- spawn_req while busy=1 is ignored; it is not queued.
- done and fail are never high together; each is high for exactly one cycle.
- occ_x/occ_y change only on entry to PROBE; otherwise they hold.

Test Plan:
- Clean placement: reset, spawn_req pulse in cycle N, rnd=16'h0A05 in N+1, occ_hit=0 → occ=(5,10) in N+2; done=1, food=(5,10), food_valid=1 in N+4; busy low in N+5.
- Out-of-range reject: rnd=16'h1903 (y=25) then 16'h0203 → first candidate never appears on occ_x/occ_y; food=(3,2); done one cycle later than the clean case.
- Occupied retry: rnd=16'h0101 with occ_hit=1 for (1,1), then 16'h0404 with occ_hit=0 → done with food=(4,4); done pulses exactly once.
- Scan fallback, MAX_TRIES=4: rnd y field held at 31; occ_hit=1 at (0,0) and (1,0) → occ addresses go (0,0),(1,0),(2,0); done with food=(2,0).
- Full grid: occ_hit tied 1, MAX_TRIES=4 → scan visits all 768 cells; fail=1 for one cycle; food_valid=0; done never asserts.
- Reset mid-search: assert reset while in PROBE → next cycle state IDLE, all outputs 0; a following spawn_req completes normally. Also check that spawn_req pulses while busy have no effect.
